// File: rtl/seg7_scan_if.sv
// Write/commit port and scanned display outputs of seg7_scan_driver.
// The core logic drives the master side; the driver implements the slave side.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int AW = $clog2(NUM_DIGITS);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [3:0]            wr_data;
    logic                  commit;
    logic                  commit_pending;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig;
    logic                  frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  commit_pending, seg, dig, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output commit_pending, seg, dig, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with shadow/active double buffer and one blank cycle per slot.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 1024,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int AW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]         PRES_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [AW-1:0]         IDX_LAST     = AW'(NUM_DIGITS - 1);
    localparam logic [31:0]           NUM_DIGITS_U = 32'(NUM_DIGITS);
    localparam logic [6:0]            SEG_MASK     = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_MASK     = DIG_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]              pres_q, pres_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0] active_q, active_d;
    logic                       pend_q, pend_d;
    logic [6:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      dig_q, dig_d;
    logic                       frame_q, frame_d;
    logic                       wrap_s;
    logic [NUM_DIGITS-1:0]      lzb_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            4'hF:    hex_to_seg = 7'h71;
            default: hex_to_seg = 7'h00;
        endcase
    endfunction

`ifdef SEG7_LZB_EN
    logic zero_above_s;

    // Mark digits above 0 whose nibble and every higher nibble are zero.
    always_comb begin
        zero_above_s = 1'b1;
        lzb_s        = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above_s = zero_above_s & (active_q[i] == 4'h0);
            lzb_s[i]     = zero_above_s;
        end
    end
`else
    assign lzb_s = '0;
`endif

    assign wrap_s = (pres_q == PRES_LAST) && (idx_q == IDX_LAST);

    // Next-state: scan counters, buffers, commit handshake and output images.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        pres_d   = pres_q;
        idx_d    = idx_q;
        seg_d    = SEG_MASK;
        dig_d    = DIG_MASK;
        frame_d  = wrap_s;

        if (bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS_U)) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
        end else begin
            shadow_d = shadow_q;
        end

        // The frame-boundary copy sees a write landing in the same cycle.
        if (wrap_s && (pend_q || bus.commit)) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end else if (bus.commit) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        if (pres_q == PRES_LAST) begin
            pres_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + AW'(1'b1);
            end
        end else begin
            pres_d = pres_q + PW'(1'b1);
            idx_d  = idx_q;
        end

        if (pres_q == '0) begin
            seg_d = SEG_MASK;
            dig_d = DIG_MASK;
        end else begin
            seg_d = (lzb_s[idx_q] ? 7'h00 : hex_to_seg(active_q[idx_q])) ^ SEG_MASK;
            dig_d = ({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_q) ^ DIG_MASK;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            seg_q    <= SEG_MASK;
            dig_q    <= DIG_MASK;
            frame_q  <= 1'b0;
        end else begin
            pres_q   <= pres_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.seg            = seg_q;
    assign bus.dig            = dig_q;
    assign bus.frame_done     = frame_q;
    assign bus.commit_pending = pend_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: unit 0 is a 4-digit active-high build, unit 1 a 6-digit active-low build,
// both with a 4-cycle slot, driven in lockstep and checked against a behavioural model.
module tb_seg7_scan_driver;
    typedef struct {
        logic [6:0] seg;
        logic [7:0] dig;
        logic       fd;
        logic       pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(4)) ifa ();
    seg7_scan_if #(.NUM_DIGITS(6)) ifb ();

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    seg7_scan_driver #(.NUM_DIGITS(6), .SCAN_DIV(4), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         nd    [2] = '{4, 6};
    logic [6:0] smask [2] = '{7'h00, 7'h7F};
    logic [7:0] dmask [2] = '{8'h00, 8'h3F};

    int         m_pres [2];
    int         m_idx  [2];
    logic [3:0] m_act  [2][8];
    logic [3:0] m_sh   [2][8];
    logic       m_pend [2];

    logic       in_we;
    logic [2:0] in_addr;
    logic [3:0] in_data;
    logic       in_commit;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_pres[u] = 0;
            m_idx[u]  = 0;
            m_pend[u] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_act[u][i] = 4'h0;
                m_sh[u][i]  = 4'h0;
            end
        end
    endtask

    function automatic exp_t model_out(int u);
        exp_t       e;
        logic       lz;
        logic [3:0] nib;
        nib = m_act[u][m_idx[u]];
        lz  = 1'b0;
`ifdef SEG7_LZB_EN
        if (m_idx[u] > 0) begin
            lz = 1'b1;
            for (int j = m_idx[u]; j < nd[u]; j++) begin
                if (m_act[u][j] != 4'h0) lz = 1'b0;
            end
        end
`endif
        e.fd = (m_pres[u] == 3) && (m_idx[u] == nd[u] - 1);
        if (m_pres[u] == 0) begin
            e.seg = smask[u];
            e.dig = dmask[u];
        end else begin
            e.seg = (lz ? 7'h00 : seg_tab[nib]) ^ smask[u];
            e.dig = (8'h01 << m_idx[u]) ^ dmask[u];
        end
        e.pend = 1'b0;
        return e;
    endfunction

    task automatic model_update(int u);
        logic [3:0] sh [8];
        int         a;
        logic       wrap;
        for (int i = 0; i < 8; i++) sh[i] = m_sh[u][i];
        a = (u == 0) ? int'(in_addr[1:0]) : int'(in_addr);
        if (in_we && a < nd[u]) sh[a] = in_data;
        wrap = (m_pres[u] == 3) && (m_idx[u] == nd[u] - 1);
        if (wrap && (m_pend[u] || in_commit)) begin
            for (int i = 0; i < 8; i++) m_act[u][i] = sh[i];
            m_pend[u] = 1'b0;
        end else if (in_commit) begin
            m_pend[u] = 1'b1;
        end
        for (int i = 0; i < 8; i++) m_sh[u][i] = sh[i];
        if (m_pres[u] == 3) begin
            m_pres[u] = 0;
            m_idx[u]  = (m_idx[u] == nd[u] - 1) ? 0 : m_idx[u] + 1;
        end else begin
            m_pres[u] = m_pres[u] + 1;
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] addr, input logic [3:0] data, input logic cm);
        in_we = we; in_addr = addr; in_data = data; in_commit = cm;
        ifa.wr_en = we; ifa.wr_addr = addr[1:0]; ifa.wr_data = data; ifa.commit = cm;
        ifb.wr_en = we; ifb.wr_addr = addr;      ifb.wr_data = data; ifb.commit = cm;
    endtask

    // One clock: push the expected post-edge outputs, clock, then pop and compare at the falling edge.
    task automatic step();
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            e = model_out(u);
            model_update(u);
            e.pend = m_pend[u];
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            e = sbq.pop_front();
            if (u == 0) begin
                check_eq("a_seg",  32'(ifa.seg),            32'(e.seg));
                check_eq("a_dig",  32'(ifa.dig),            32'(e.dig));
                check_eq("a_fd",   32'(ifa.frame_done),     32'(e.fd));
                check_eq("a_pend", 32'(ifa.commit_pending), 32'(e.pend));
            end else begin
                check_eq("b_seg",  32'(ifb.seg),            32'(e.seg));
                check_eq("b_dig",  32'(ifb.dig),            32'(e.dig));
                check_eq("b_fd",   32'(ifb.frame_done),     32'(e.fd));
                check_eq("b_pend", 32'(ifb.commit_pending), 32'(e.pend));
            end
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_off(input string tag);
        check_eq({tag, "_a_seg"}, 32'(ifa.seg),            32'h00);
        check_eq({tag, "_a_dig"}, 32'(ifa.dig),            32'h0);
        check_eq({tag, "_a_fd"},  32'(ifa.frame_done),     32'h0);
        check_eq({tag, "_a_pnd"}, 32'(ifa.commit_pending), 32'h0);
        check_eq({tag, "_b_seg"}, 32'(ifb.seg),            32'h7F);
        check_eq({tag, "_b_dig"}, 32'(ifb.dig),            32'h3F);
        check_eq({tag, "_b_fd"},  32'(ifb.frame_done),     32'h0);
        check_eq({tag, "_b_pnd"}, 32'(ifb.commit_pending), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_off("reset");
        rst_n = 1'b1;

        // Idle scan of two frames, all digits showing zero.
        idle(32);

        // Shadow writes alone never reach the display; commit lands at the next wrap.
        drive(1'b1, 3'd0, 4'h7, 1'b0); step();
        drive(1'b1, 3'd1, 4'hC, 1'b0); step();
        drive(1'b1, 3'd2, 4'h5, 1'b0); step();
        drive(1'b1, 3'd3, 4'hA, 1'b0); step();
        idle(32);
        drive(1'b0, 3'd0, 4'h0, 1'b1); step();
        drive(1'b0, 3'd0, 4'h0, 1'b1); step();
        idle(40);

        // Commit and write in unit 0's wrap cycle.
        idle(1);
        for (int k = 0; k < 64 && !(m_pres[0] == 3 && m_idx[0] == 3); k++) step();
        drive(1'b1, 3'd0, 4'h9, 1'b1); step();
        idle(20);

        // Out-of-range address on the 6-digit unit, then reset mid-frame.
        drive(1'b1, 3'd7, 4'hF, 1'b0); step();
        drive(1'b0, 3'd0, 4'h0, 1'b1); step();
        idle(30);
        drive(1'b1, 3'd2, 4'h8, 1'b1); step();
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_off("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 4'h0, 1'b1); step();
        idle(30);

        // Leading-zero pattern {0,0,4,0}.
        drive(1'b1, 3'd1, 4'h4, 1'b1); step();
        idle(56);

        // Digit 0 = 1 for the active-low polarity check.
        drive(1'b1, 3'd0, 4'h1, 1'b1); step();
        idle(50);

        // Random traffic.
        for (int k = 0; k < 120; k++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0));
            step();
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
